// File: rtl/pipeline_decode.sv
// Decode stage register: splits the fetched word into fields, immediate and control bits.
// Optional load-use hazard detection is built when PIPELINE_DECODE_HAZARD_EN is defined.
module pipeline_decode #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [31:0] instruction_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pcsrc_i,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        ex_mem_read_i,
   input  logic [4:0]  ex_rd_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcplus4_o,
   output logic [6:0]  opcode_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [2:0]  funct3_o,
   output logic [6:0]  funct7_o,
   output logic [31:0] imm_o,
   output logic        illegal_o,
   output logic        reg_write_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        branch_o,
   output logic        jump_o,
   output logic        alu_src_o,
   output logic        stall_req_o
);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpReg    = 7'b0110011;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic        illegal;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
   } dec_t;

   logic [31:0] src;
   dec_t        dec_d, dec_q;
   logic        valid_q;
   logic [31:0] pc_q, pcplus4_q;

   // Flushed or invalid slots decode the NOP word so downstream sees a harmless instruction.
   always_comb begin
      src = (flush_i || !valid_i) ? NOP_INSTR : instruction_i;
      dec_d = '0;
      dec_d.opcode = src[6:0];
      dec_d.rd     = src[11:7];
      dec_d.rs1    = src[19:15];
      dec_d.rs2    = src[24:20];
      dec_d.funct3 = src[14:12];
      dec_d.funct7 = src[31:25];
      case (src[6:0])
         OpReg: begin
            dec_d.reg_write = 1'b1;
         end
         OpLoad: begin
            dec_d.imm       = {{20{src[31]}}, src[31:20]};
            dec_d.reg_write = 1'b1;
            dec_d.mem_read  = 1'b1;
            dec_d.alu_src   = 1'b1;
         end
         OpImm: begin
            dec_d.imm       = {{20{src[31]}}, src[31:20]};
            dec_d.reg_write = 1'b1;
            dec_d.alu_src   = 1'b1;
         end
         OpJalr: begin
            dec_d.imm       = {{20{src[31]}}, src[31:20]};
            dec_d.reg_write = 1'b1;
            dec_d.jump      = 1'b1;
            dec_d.alu_src   = 1'b1;
         end
         OpStore: begin
            dec_d.imm       = {{20{src[31]}}, src[31:25], src[11:7]};
            dec_d.mem_write = 1'b1;
            dec_d.alu_src   = 1'b1;
         end
         OpBranch: begin
            dec_d.imm    = {{19{src[31]}}, src[31], src[7], src[30:25], src[11:8], 1'b0};
            dec_d.branch = 1'b1;
         end
         OpLui, OpAuipc: begin
            dec_d.imm       = {src[31:12], 12'h000};
            dec_d.reg_write = 1'b1;
            dec_d.alu_src   = 1'b1;
         end
         OpJal: begin
            dec_d.imm = {{11{src[31]}}, src[31], src[19:12], src[20], src[30:21], 1'b0};
            dec_d.reg_write = 1'b1;
            dec_d.jump      = 1'b1;
            dec_d.alu_src   = 1'b1;
         end
         // Also catches every word whose low two bits are not 2'b11.
         default: begin
            dec_d.illegal = 1'b1;
         end
      endcase
      if (dec_d.rd == 5'd0) begin
         dec_d.reg_write = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         pcplus4_q <= '0;
         dec_q     <= '0;
      end else if (flush_i) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         pcplus4_q <= '0;
         dec_q     <= dec_d;
      end else if (!stall_i) begin
         valid_q   <= valid_i;
         pc_q      <= pc_i;
         pcplus4_q <= pcsrc_i;
         dec_q     <= dec_d;
      end
   end

   assign valid_o     = valid_q;
   assign pc_o        = pc_q;
   assign pcplus4_o   = pcplus4_q;
   assign opcode_o    = dec_q.opcode;
   assign rd_o        = dec_q.rd;
   assign rs1_o       = dec_q.rs1;
   assign rs2_o       = dec_q.rs2;
   assign funct3_o    = dec_q.funct3;
   assign funct7_o    = dec_q.funct7;
   assign imm_o       = dec_q.imm;
   assign illegal_o   = dec_q.illegal;
   assign reg_write_o = dec_q.reg_write;
   assign mem_read_o  = dec_q.mem_read;
   assign mem_write_o = dec_q.mem_write;
   assign branch_o    = dec_q.branch;
   assign jump_o      = dec_q.jump;
   assign alu_src_o   = dec_q.alu_src;

`ifdef PIPELINE_DECODE_HAZARD_EN
   logic uses_rs2;
   // Only R, S and B formats actually read rs2; elsewhere those bits are immediate.
   assign uses_rs2 = (dec_q.opcode == OpReg) || (dec_q.opcode == OpStore) ||
                     (dec_q.opcode == OpBranch);
   assign stall_req_o = valid_q && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                        ((ex_rd_i == dec_q.rs1) || (uses_rs2 && (ex_rd_i == dec_q.rs2)));
`else
   logic unused_hazard;
   assign unused_hazard = ^{ex_mem_read_i, ex_rd_i};
   assign stall_req_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_decode.sv
// Directed bench for pipeline_decode: decode vectors, stall/flush priority, hazard and reset.
module tb_pipeline_decode;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [31:0] instruction_i, pc_i, pcsrc_i;
   logic        valid_i, stall_i, flush_i, ex_mem_read_i;
   logic [4:0]  ex_rd_i;
   logic        valid_o, illegal_o, reg_write_o, mem_read_o, mem_write_o;
   logic        branch_o, jump_o, alu_src_o, stall_req_o;
   logic [31:0] pc_o, pcplus4_o, imm_o;
   logic [6:0]  opcode_o, funct7_o;
   logic [4:0]  rd_o, rs1_o, rs2_o;
   logic [2:0]  funct3_o;

   int checks = 0;
   int errors = 0;
   logic haz_on;

   pipeline_decode dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .instruction_i(instruction_i), .pc_i(pc_i),
      .pcsrc_i(pcsrc_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
      .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i), .valid_o(valid_o), .pc_o(pc_o),
      .pcplus4_o(pcplus4_o), .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
      .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o), .illegal_o(illegal_o),
      .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .branch_o(branch_o), .jump_o(jump_o), .alu_src_o(alu_src_o), .stall_req_o(stall_req_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Controls packed as {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src}.
   function automatic logic [31:0] ctl();
      return {25'd0, illegal_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
              alu_src_o};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
      instruction_i = ins;
      pc_i          = pc;
      pcsrc_i       = pc + 32'd4;
      valid_i       = v;
   endtask

   initial begin
`ifdef PIPELINE_DECODE_HAZARD_EN
      haz_on = 1'b1;
`else
      haz_on = 1'b0;
`endif
      reset_ni = 1'b0;
      stall_i = 1'b0; flush_i = 1'b0; ex_mem_read_i = 1'b0; ex_rd_i = 5'd0;
      drive(32'h00500093, 32'h10, 1'b1);
      #13;
      chk("reset_valid", valid_o, 0);
      chk("reset_pc", pc_o, 0);
      chk("reset_imm", imm_o, 0);
      chk("reset_ctl", ctl(), 0);
      chk("reset_stallreq", stall_req_o, 0);

      // addi x1,x0,5 captured on first edge after release
      @(negedge clk_i); reset_ni = 1'b1;
      @(negedge clk_i);
      chk("addi_valid", valid_o, 1);
      chk("addi_rd", rd_o, 1);
      chk("addi_imm", imm_o, 5);
      chk("addi_ctl", ctl(), 32'b0100001);
      chk("addi_pc", pc_o, 32'h10);
      chk("addi_pc4", pcplus4_o, 32'h14);
      // rs2 field of an I-type is immediate bits: no hazard
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; #1;
      chk("addi_rs2_nohaz", stall_req_o, 0);
      ex_mem_read_i = 1'b0; ex_rd_i = 5'd0;

      drive(32'hFE000EE3, 32'h14, 1'b1);
      @(negedge clk_i);
      chk("beq_imm", imm_o, 32'hFFFFFFFC);
      chk("beq_ctl", ctl(), 32'b0000100);
      chk("beq_opc", opcode_o, 7'h63);

      drive(32'h00528333, 32'h20, 1'b1);
      @(negedge clk_i);
      chk("add_rd", rd_o, 6);
      chk("add_rs1", rs1_o, 5);
      chk("add_imm", imm_o, 0);
      chk("add_ctl", ctl(), 32'b0100000);

      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(32'hFFC0A383 + i, 32'h100 + 4 * i, 1'b1);
         @(negedge clk_i);
         chk("stall_rd", rd_o, 6);
         chk("stall_pc", pc_o, 32'h20);
         chk("stall_valid", valid_o, 1);
      end
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; #1;
      chk("haz_rs", stall_req_o, {31'd0, haz_on});
      ex_rd_i = 5'd0; #1;
      chk("haz_x0", stall_req_o, 0);
      ex_rd_i = 5'd6; #1;
      chk("haz_rd_only", stall_req_o, 0);
      ex_rd_i = 5'd5; ex_mem_read_i = 1'b0; #1;
      chk("haz_noload", stall_req_o, 0);
      ex_mem_read_i = 1'b1;

      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_valid", valid_o, 0);
      chk("flush_opc", opcode_o, 7'h13);
      chk("flush_pc", pc_o, 0);
      chk("flush_pc4", pcplus4_o, 0);
      chk("flush_ctl", ctl(), 32'b0000001);
      chk("flush_rd", rd_o, 0);
      chk("flush_stallreq", stall_req_o, 0);
      flush_i = 1'b0; stall_i = 1'b0; ex_mem_read_i = 1'b0; ex_rd_i = 5'd0;

      drive(32'h00528333, 32'h30, 1'b0);
      @(negedge clk_i);
      chk("inv_valid", valid_o, 0);
      chk("inv_opc", opcode_o, 7'h13);

      drive(32'hFFFFFFFF, 32'h34, 1'b1);
      @(negedge clk_i);
      chk("ill_ctl", ctl(), 32'b1000000);
      chk("ill_imm", imm_o, 0);
      chk("ill_valid", valid_o, 1);
      chk("ill_rd", rd_o, 31);

      drive(32'h00500090, 32'h38, 1'b1);
      @(negedge clk_i);
      chk("ill_low2", ctl(), 32'b1000000);

      drive(32'h00512423, 32'h3C, 1'b1);
      @(negedge clk_i);
      chk("sw_imm", imm_o, 8);
      chk("sw_ctl", ctl(), 32'b0001001);
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; #1;
      chk("sw_haz_rs2", stall_req_o, {31'd0, haz_on});
      ex_mem_read_i = 1'b0; ex_rd_i = 5'd0;

      drive(32'hFFC0A383, 32'h40, 1'b1);
      @(negedge clk_i);
      chk("lw_imm", imm_o, 32'hFFFFFFFC);
      chk("lw_ctl", ctl(), 32'b0110001);
      chk("lw_f3", funct3_o, 3'b010);

      drive(32'h123451B7, 32'h44, 1'b1);
      @(negedge clk_i);
      chk("lui_imm", imm_o, 32'h12345000);
      chk("lui_ctl", ctl(), 32'b0100001);

      drive(32'h008000EF, 32'h48, 1'b1);
      @(negedge clk_i);
      chk("jal_imm", imm_o, 8);
      chk("jal_ctl", ctl(), 32'b0100011);

      // asynchronous reset in mid-stall, between edges
      stall_i = 1'b1;
      @(posedge clk_i); #2;
      reset_ni = 1'b0; #1;
      chk("areset_valid", valid_o, 0);
      chk("areset_pc", pc_o, 0);
      chk("areset_imm", imm_o, 0);
      chk("areset_ctl", ctl(), 0);
      @(negedge clk_i);
      stall_i = 1'b0; reset_ni = 1'b1;
      drive(32'h00500093, 32'h80, 1'b1);
      @(negedge clk_i);
      chk("post_reset_pc", pc_o, 32'h80);
      chk("post_reset_valid", valid_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
